// File: rtl/cpu_pkg.sv
// Core-wide constants shared by decode, register file, operand fetch and execute.
// Also holds the forwarding-match helper used by the operand bypass muxes.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_W-1:0] OP_AND  = 6'd3;
    localparam logic [OP_W-1:0] OP_OR   = 6'd4;
    localparam logic [OP_W-1:0] OP_LOAD = 6'd5;
    localparam logic [OP_W-1:0] OP_STOR = 6'd6;
    localparam logic [OP_W-1:0] OP_BR   = 6'd7;

    // True when a pending write targets the register being read.
    function automatic logic fwd_hit(input logic en,
                                     input logic [ADDR_W-1:0] wr_addr,
                                     input logic [ADDR_W-1:0] rd_addr);
        fwd_hit = en && (wr_addr == rd_addr);
    endfunction

endpackage

// File: rtl/bypass_mux.sv
// Three-way priority operand select: live writeback, then one-edge-old
// writeback still invisible in the register file, then register file data.
module bypass_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              h_v,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_data,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] operand
);
    import cpu_pkg::*;

    // Newest producer wins.
    always_comb begin
        operand = q;
        if (fwd_hit(wb_en, wb_addr, rs)) begin
            operand = wb_data;
        end else if (fwd_hit(h_v, h_addr, rs)) begin
            operand = h_data;
        end else begin
            operand = q;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: drives RF read ports, resolves both operands against
// in-flight writebacks and holds them in the ID/EX register under valid/ready.
module operand_fetch #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int OP_W   = cpu_pkg::OP_W
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] Ra,
    output logic [ADDR_W-1:0] Rb,
    output logic              RD_en,
    input  logic [DATA_W-1:0] Qa,
    input  logic [DATA_W-1:0] Qb,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [OP_W-1:0]   ex_op,
    output logic [DATA_W-1:0] ex_imm
);

    logic              h_v;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              capture;

    assign Ra       = in_rs1;
    assign Rb       = in_rs2;
    assign RD_en    = in_valid;
    assign in_ready = !ex_valid || ex_ready;
    // RD_en gates capture, so undriven RF data is never latched.
    assign capture  = in_valid && in_ready && !flush;

    bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_a (
        .rs      (in_rs1),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .h_v     (h_v),
        .h_addr  (h_addr),
        .h_data  (h_data),
        .q       (Qa),
        .operand (opnd_a)
    );

    bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_b (
        .rs      (in_rs2),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .h_v     (h_v),
        .h_addr  (h_addr),
        .h_data  (h_data),
        .q       (Qb),
        .operand (opnd_b)
    );

    // History of the last writeback; the RF shows it only one edge later.
    // Writebacks are never flushed.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            h_v    <= 1'b0;
            h_addr <= {ADDR_W{1'b0}};
            h_data <= {DATA_W{1'b0}};
        end else begin
            h_v    <= wb_en;
            h_addr <= wb_addr;
            h_data <= wb_data;
        end
    end

    // ID/EX pipeline register; flush overrides a stall.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ex_valid <= 1'b0;
            ex_a     <= {DATA_W{1'b0}};
            ex_b     <= {DATA_W{1'b0}};
            ex_rd    <= {ADDR_W{1'b0}};
            ex_op    <= {OP_W{1'b0}};
            ex_imm   <= {DATA_W{1'b0}};
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (capture) begin
            ex_valid <= 1'b1;
            ex_a     <= opnd_a;
            ex_b     <= opnd_b;
            ex_rd    <= in_rd;
            ex_op    <= in_op;
            ex_imm   <= in_imm;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch: a lagging RF model feeds Qa/Qb and an
// architectural register array predicts the operands execute must see.
module tb_operand_fetch;
    import cpu_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              flush, in_valid, in_ready;
    logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd, Ra, Rb;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_imm, Qa, Qb;
    logic              RD_en, wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid, ex_ready;
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
    logic [ADDR_W-1:0] ex_rd;
    logic [OP_W-1:0]   ex_op;

    always #5 CLK = ~CLK;

    operand_fetch dut (
        .CLK(CLK), .RST_n(RST_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op), .in_imm(in_imm),
        .Ra(Ra), .Rb(Rb), .RD_en(RD_en), .Qa(Qa), .Qb(Qb),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .ex_op(ex_op), .ex_imm(ex_imm)
    );

    // rf_vis is what the RF shows; arch is the true register state.
    logic [DATA_W-1:0] rf_vis [32];
    logic [DATA_W-1:0] arch   [32];
    logic              pend_en;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              rf_only;

    assign Qa = rf_vis[in_rs1];
    assign Qb = rf_vis[in_rs2];

    logic              e_valid;
    logic [DATA_W-1:0] e_a, e_b, e_imm;
    logic [ADDR_W-1:0] e_rd;
    logic [OP_W-1:0]   e_op;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rdy, input logic fl);
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = 5'($urandom);
        in_op    = 6'($urandom);
        in_imm   = $urandom;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        ex_ready = rdy;
        flush    = fl;
    endtask

    task automatic set_reg(input int idx, input logic [31:0] val);
        rf_vis[idx] = val;
        arch[idx]   = val;
    endtask

    task automatic check_ex(input string tag);
        check({tag, "_valid"}, 32'(ex_valid), 32'(e_valid));
        check({tag, "_a"},     ex_a,          e_a);
        check({tag, "_b"},     ex_b,          e_b);
        check({tag, "_rd"},    32'(ex_rd),    32'(e_rd));
        check({tag, "_op"},    32'(ex_op),    32'(e_op));
        check({tag, "_imm"},   ex_imm,        e_imm);
    endtask

    // Value a reader should get: the write landing this cycle, else the register contents.
    function automatic logic [31:0] want(input logic [4:0] rs);
        if (wb_en && wb_addr == rs) return wb_data;
        if (rf_only) return rf_vis[rs];
        return arch[rs];
    endfunction

    // One clock: entered at posedge+1 with inputs driven, leaves at next posedge+1.
    task automatic cycle(input string tag);
        logic [31:0] na, nb;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(!e_valid || ex_ready));
        check({tag, "_ports"}, {21'd0, Ra, Rb, RD_en}, {21'd0, in_rs1, in_rs2, in_valid});
        na = want(in_rs1);
        nb = want(in_rs2);
        if (flush) begin
            e_valid = 1'b0;
        end else if (in_valid && (!e_valid || ex_ready)) begin
            e_valid = 1'b1;
            e_a = na; e_b = nb; e_rd = in_rd; e_op = in_op; e_imm = in_imm;
            rf_only = 1'b0;
        end else if (ex_ready) begin
            e_valid = 1'b0;
        end
        @(posedge CLK);
        #1;
        if (wb_en) arch[wb_addr] = wb_data;
        if (pend_en) rf_vis[pend_addr] = pend_data;
        pend_en = wb_en; pend_addr = wb_addr; pend_data = wb_data;
        check_ex(tag);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) set_reg(i, $urandom);
        pend_en = 1'b0; pend_addr = 5'd0; pend_data = 32'd0; rf_only = 1'b0;
        e_valid = 1'b0; e_a = 32'd0; e_b = 32'd0; e_rd = 5'd0; e_op = 6'd0; e_imm = 32'd0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        RST_n = 1'b0;
        #2;
        check_ex("reset");
        RST_n = 1'b1;
        @(posedge CLK);
        #1;

        // Basic read
        set_reg(3, 32'h11); set_reg(4, 32'h22);
        drive(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle("basic");
        check("basic_a_const", ex_a, 32'h11);
        check("basic_b_const", ex_b, 32'h22);

        // Same-cycle bypass with stale RF
        set_reg(5, 32'h0);
        drive(1'b1, 5'd5, 5'd4, 1'b1, 5'd5, 32'hDEAD, 1'b1, 1'b0);
        cycle("same_byp");
        check("same_byp_const", ex_a, 32'hDEAD);

        // History bypass, then RF catches up
        set_reg(6, 32'h0);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd6, 32'hBEEF, 1'b1, 1'b0);
        cycle("hist_wr");
        drive(1'b1, 5'd1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        check("hist_rf_stale", Qb, 32'h0);
        cycle("hist_byp");
        check("hist_byp_const", ex_b, 32'hBEEF);
        drive(1'b1, 5'd1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle("hist_rf");
        check("hist_rf_const", ex_b, 32'hBEEF);

        // Live writeback beats history
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1, 1'b1, 1'b0);
        cycle("prio_wr");
        drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h2, 1'b1, 1'b0);
        cycle("prio");
        check("prio_a_const", ex_a, 32'h2);
        check("prio_b_const", ex_b, 32'h2);

        // Stall three cycles, then flush while still stalled
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'($urandom), 5'($urandom), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            cycle("stall");
        end
        drive(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        cycle("flush");
        check("flush_valid_const", 32'(ex_valid), 32'd0);

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0));
            cycle("rand");
        end

        // Async reset mid-stall with a write still in flight to the RF
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle("pre_rst_idle");
        set_reg(9, 32'h77);
        drive(1'b1, 5'd2, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cycle("pre_rst_load");
        drive(1'b1, 5'd2, 5'd2, 1'b1, 5'd9, 32'h55, 1'b0, 1'b0);
        cycle("pre_rst_stall");
        #2;
        RST_n = 1'b0;
        #1;
        e_valid = 1'b0; e_a = 32'd0; e_b = 32'd0; e_rd = 5'd0; e_op = 6'd0; e_imm = 32'd0;
        rf_only = 1'b1;
        check_ex("async_rst");
        #1;
        RST_n = 1'b1;
        drive(1'b1, 5'd9, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cycle("post_rst");
        check("post_rst_rf_only", ex_a, 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
